// File: rtl/dw_lod_norm_pipe_pkg.sv
// Shared definitions for the leading-one normalizer pipeline (dw_lod_norm_pipe).
// Optional statistics counters are enabled by defining DW_LOD_NORM_STATS_EN.
package dw_lod_pkg;

  localparam int STAT_CNT_W    = 16;
  localparam int A_WIDTH_DEF   = 8;
  localparam int EXP_WIDTH_DEF = 8;

  // Shift-count width: wide enough to hold the value w itself (all-zero operand).
  function automatic int lzc_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // Stage payload for the default datapath configuration.
  typedef struct packed {
    logic [A_WIDTH_DEF-1:0]   a;
    logic [EXP_WIDTH_DEF-1:0] exp;
  } lod_payload_t;

endpackage

// File: rtl/dw_lod_norm_pipe_if.sv
// Handshake/data bundle of dw_lod_norm_pipe; slave = the pipe, master = its neighbours.
// Stat counter signals exist only when DW_LOD_NORM_STATS_EN is defined.
interface dw_lod_norm_pipe_if
  import dw_lod_pkg::*;
#(
  parameter int a_width    = 8,
  parameter int addr_width = 4,
  parameter int exp_width  = 8
);

  // Valid/ready: a beat moves on a rising edge where valid & ready are both high;
  // the sender holds valid and data stable until then, and ready never depends on valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [a_width-1:0]    in_a;
  logic [exp_width-1:0]  in_exp;
  logic                  out_valid;
  logic                  out_ready;
  logic [a_width-1:0]    out_norm;
  logic [addr_width-1:0] out_shift;
  logic [exp_width-1:0]  out_exp;
  logic                  out_zero;
  logic                  out_uflow;

`ifdef DW_LOD_NORM_STATS_EN
  logic [STAT_CNT_W-1:0] stat_uflow_cnt;
  logic [STAT_CNT_W-1:0] stat_zero_cnt;

  modport slave (
    input  in_valid, in_a, in_exp, out_ready,
    output in_ready, out_valid, out_norm, out_shift, out_exp, out_zero, out_uflow,
    output stat_uflow_cnt, stat_zero_cnt
  );

  modport master (
    output in_valid, in_a, in_exp, out_ready,
    input  in_ready, out_valid, out_norm, out_shift, out_exp, out_zero, out_uflow,
    input  stat_uflow_cnt, stat_zero_cnt
  );
`else
  modport slave (
    input  in_valid, in_a, in_exp, out_ready,
    output in_ready, out_valid, out_norm, out_shift, out_exp, out_zero, out_uflow
  );

  modport master (
    output in_valid, in_a, in_exp, out_ready,
    input  in_ready, out_valid, out_norm, out_shift, out_exp, out_zero, out_uflow
  );
`endif

endinterface

// File: rtl/dw_lod_norm_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero operand yields a_width.
module dw_lod_lzc #(
  parameter int a_width    = 8,
  parameter int addr_width = 4
) (
  input  logic [a_width-1:0]    a_i,
  output logic [addr_width-1:0] lzc_o
);

  // Scan upward so the highest set bit is the last one to write the result.
  always_comb begin
    lzc_o = addr_width'(a_width);
    for (int i = 0; i < a_width; i++) begin
      if (a_i[i]) lzc_o = addr_width'(a_width - 1 - i);
    end
  end

endmodule

// File: rtl/dw_lod_norm_pipe.sv
// Two-stage normalizer: S1 captures operand + leading-zero count, S2 shifts and adjusts exponent.
// Defining DW_LOD_NORM_STATS_EN adds saturating underflow/zero output-transfer counters.
module dw_lod_norm_pipe
  import dw_lod_pkg::*;
#(
  parameter int a_width    = 8,
  parameter int addr_width = lzc_width(a_width),
  parameter int exp_width  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dw_lod_norm_pipe_if.slave bus
);

  localparam int CW = (exp_width > addr_width) ? exp_width : addr_width;

  typedef struct packed {
    logic [a_width-1:0]   a;
    logic [exp_width-1:0] exp;
  } stage_t;

  stage_t                s1_q;
  logic [addr_width-1:0] s1_lzc_q;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  rdy_en_q;
  logic [addr_width-1:0] lzc_w;

  logic [a_width-1:0]    norm_q, norm_d;
  logic [addr_width-1:0] shift_q;
  logic [exp_width-1:0]  exp_q, exp_d;
  logic                  zero_q, zero_d;
  logic                  uflow_q, uflow_d;

  logic                  s2_adv;
  logic                  in_ready;
  logic                  in_fire;
  logic [CW-1:0]         exp_ext, lzc_ext;

  dw_lod_lzc #(
    .a_width    (a_width),
    .addr_width (addr_width)
  ) u_lzc (
    .a_i   (bus.in_a),
    .lzc_o (lzc_w)
  );

  // Ready is held low until the first clock after reset release.
  always_comb begin
    s2_adv     = s1_valid_q & (~s2_valid_q | bus.out_ready);
    in_ready   = rdy_en_q & (~s1_valid_q | s2_adv);
    in_fire    = bus.in_valid & in_ready;
    s1_valid_d = in_fire | (s1_valid_q & ~s2_adv);
    s2_valid_d = s2_adv | (s2_valid_q & ~bus.out_ready);
  end

  always_comb begin
    norm_d  = s1_q.a << s1_lzc_q;
    zero_d  = (s1_q.a == '0);
    exp_ext = CW'(s1_q.exp);
    lzc_ext = CW'(s1_lzc_q);
    exp_d   = '0;
    uflow_d = 1'b0;
    if (!zero_d) begin
      if (exp_ext < lzc_ext) uflow_d = 1'b1;
      else                   exp_d   = exp_width'(exp_ext - lzc_ext);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_lzc_q   <= '0;
      norm_q     <= '0;
      shift_q    <= '0;
      exp_q      <= '0;
      zero_q     <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_q.a   <= bus.in_a;
        s1_q.exp <= bus.in_exp;
        s1_lzc_q <= lzc_w;
      end
      if (s2_adv) begin
        norm_q  <= norm_d;
        shift_q <= s1_lzc_q;
        exp_q   <= exp_d;
        zero_q  <= zero_d;
        uflow_q <= uflow_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_norm  = norm_q;
  assign bus.out_shift = shift_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_uflow = uflow_q;

`ifdef DW_LOD_NORM_STATS_EN
  logic                  out_fire;
  logic [STAT_CNT_W-1:0] uflow_cnt_q, zero_cnt_q;

  assign out_fire = s2_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow_cnt_q <= '0;
      zero_cnt_q  <= '0;
    end else begin
      if (out_fire && uflow_q && (uflow_cnt_q != '1)) uflow_cnt_q <= uflow_cnt_q + 1'b1;
      if (out_fire && zero_q && (zero_cnt_q != '1))   zero_cnt_q  <= zero_cnt_q + 1'b1;
    end
  end

  assign bus.stat_uflow_cnt = uflow_cnt_q;
  assign bus.stat_zero_cnt  = zero_cnt_q;
`endif

endmodule

// File: tb/tb_dw_lod_norm_pipe.sv
// Directed/table-driven bench for dw_lod_norm_pipe (stat checks when DW_LOD_NORM_STATS_EN is set).
module tb_dw_lod_norm_pipe;
  import dw_lod_pkg::*;

  typedef struct packed {
    logic [7:0] norm;
    logic [3:0] shift;
    logic [7:0] exp;
    logic       zero;
    logic       uflow;
  } res_t;

  localparam int RW = $bits(res_t);

  typedef struct {
    lod_payload_t in;
    res_t         exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   tally_uflow = 0;
  int   tally_zero  = 0;

  logic [RW-1:0] exp_q[$];
  logic [7:0]    st_a[$];
  logic [7:0]    st_e[$];
  int            acc_cyc[$];
  int            out_cyc[$];
  vec_t          vecs[8];

  dw_lod_norm_pipe_if #(.a_width(8), .addr_width(4), .exp_width(8)) bus ();

  dw_lod_norm_pipe #(.a_width(8), .addr_width(4), .exp_width(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t get_out();
    res_t r;
    r.norm  = bus.out_norm;
    r.shift = bus.out_shift;
    r.exp   = bus.out_exp;
    r.zero  = bus.out_zero;
    r.uflow = bus.out_uflow;
    return r;
  endfunction

  function automatic res_t ref_model(input logic [7:0] a, input logic [7:0] e);
    res_t       r;
    logic [7:0] t;
    int         s;
    r = '0;
    t = a;
    s = 0;
    if (a == 8'h00) begin
      r.shift = 4'd8;
      r.zero  = 1'b1;
      return r;
    end
    while (!t[7]) begin
      t = t << 1;
      s++;
    end
    r.norm  = t;
    r.shift = 4'(s);
    if (int'(e) < s) r.uflow = 1'b1;
    else             r.exp   = 8'(int'(e) - s);
    return r;
  endfunction

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_res(input string name, input res_t got, input res_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got norm=%b shift=%0d exp=%0d zero=%b uflow=%b, required norm=%b shift=%0d exp=%0d zero=%b uflow=%b",
               name, got.norm, got.shift, got.exp, got.zero, got.uflow,
               want.norm, want.shift, want.exp, want.zero, want.uflow);
    end
  endtask

  task automatic tally(input res_t r);
    if (r.uflow) tally_uflow++;
    if (r.zero)  tally_zero++;
  endtask

  // driver: single operand with out_ready=1; called just after a rising edge
  task automatic apply_one(input logic [7:0] a, input logic [7:0] e, output res_t got, output int lat);
    int   n;
    logic rdy;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_exp    = e;
    n = 0;
    do begin
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 20);
    bus.in_valid = 1'b0;
    check_val("accept_timeout", int'(rdy), 1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = get_out();
    @(posedge clk);
    #1;
  endtask

  // driver + scoreboard for a stream held in st_a/st_e; mode 0 = ready from cycle 6, 1 = random ready
  task automatic run_stream(input int mode);
    int   c, idx, nout, n;
    logic rdy, ov, prev_stall;
    res_t cur, prev, want;
    c = 0; idx = 0; nout = 0; n = st_a.size();
    prev_stall = 1'b0;
    prev = '0;
    acc_cyc.delete();
    out_cyc.delete();
    exp_q.delete();
    while (nout < n && c < 5000) begin
      bus.out_ready = (mode == 0) ? (c >= 6) : ($urandom_range(0, 3) != 0);
      if (idx < n) begin
        bus.in_valid = 1'b1;
        bus.in_a     = st_a[idx];
        bus.in_exp   = st_e[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      rdy = bus.in_ready;
      ov  = bus.out_valid;
      cur = get_out();
      if (ov && prev_stall) check_res("stall_hold", cur, prev);
      if (ov && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_output", 1, 0);
        end else begin
          want = res_t'(exp_q.pop_front());
          check_res("stream_out", cur, want);
          tally(want);
        end
        out_cyc.push_back(c);
        nout++;
      end
      prev_stall = ov && !bus.out_ready;
      prev = cur;
      if (bus.in_valid && rdy) begin
        exp_q.push_back(RW'(ref_model(st_a[idx], st_e[idx])));
        acc_cyc.push_back(c);
        idx++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_val("stream_count", nout, n);
  endtask

  initial begin
    res_t got;
    int   lat;
    int   want_acc[4];
    int   want_out[4];

    vecs[0] = '{in: '{a: 8'b0001_0110, exp: 8'd10},  exp: '{8'b1011_0000, 4'd3, 8'd7,   1'b0, 1'b0}};
    vecs[1] = '{in: '{a: 8'h00,        exp: 8'd20},  exp: '{8'h00,        4'd8, 8'd0,   1'b1, 1'b0}};
    vecs[2] = '{in: '{a: 8'h01,        exp: 8'd2},   exp: '{8'h80,        4'd7, 8'd0,   1'b0, 1'b1}};
    vecs[3] = '{in: '{a: 8'h01,        exp: 8'd7},   exp: '{8'h80,        4'd7, 8'd0,   1'b0, 1'b0}};
    vecs[4] = '{in: '{a: 8'h80,        exp: 8'd0},   exp: '{8'h80,        4'd0, 8'd0,   1'b0, 1'b0}};
    vecs[5] = '{in: '{a: 8'hFF,        exp: 8'd255}, exp: '{8'hFF,        4'd0, 8'd255, 1'b0, 1'b0}};
    vecs[6] = '{in: '{a: 8'h05,        exp: 8'd4},   exp: '{8'hA0,        4'd5, 8'd0,   1'b0, 1'b1}};
    vecs[7] = '{in: '{a: 8'h40,        exp: 8'd1},   exp: '{8'h80,        4'd1, 8'd0,   1'b0, 1'b0}};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", int'(bus.out_valid), 0);
    check_res("rst_outputs", get_out(), '0);
    check_val("rst_in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_in_ready", int'(bus.in_ready), 1);

    // table-driven single operands
    foreach (vecs[i]) begin
      apply_one(vecs[i].in.a, vecs[i].in.exp, got, lat);
      check_val($sformatf("vec%0d_latency", i), lat, 2);
      check_res($sformatf("vec%0d_result", i), got, vecs[i].exp);
      tally(vecs[i].exp);
    end

    // backpressure: 4 back-to-back operands, out_ready low for cycles 0-5
    st_a.delete(); st_e.delete();
    st_a.push_back(8'h16); st_e.push_back(8'd10);
    st_a.push_back(8'h01); st_e.push_back(8'd2);
    st_a.push_back(8'h00); st_e.push_back(8'd20);
    st_a.push_back(8'h33); st_e.push_back(8'd40);
    run_stream(0);
    want_acc = '{0, 1, 6, 7};
    want_out = '{6, 7, 8, 9};
    check_val("bp_acc_n", acc_cyc.size(), 4);
    check_val("bp_out_n", out_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_cyc.size()) check_val($sformatf("bp_accept_cycle%0d", i), acc_cyc[i], want_acc[i]);
      if (i < out_cyc.size()) check_val($sformatf("bp_output_cycle%0d", i), out_cyc[i], want_out[i]);
    end

    // reset with two items in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h16;
    bus.in_exp    = 8'd10;
    @(posedge clk); #1;
    bus.in_a      = 8'h01;
    bus.in_exp    = 8'd7;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    check_val("mid_pre_valid", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", int'(bus.out_valid), 0);
    check_res("mid_rst_outputs", get_out(), '0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tally_uflow = 0;
    tally_zero  = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("mid_no_stale%0d", i), int'(bus.out_valid), 0);
    end
    apply_one(vecs[6].in.a, vecs[6].in.exp, got, lat);
    check_val("mid_post_latency", lat, 2);
    check_res("mid_post_result", got, vecs[6].exp);
    tally(vecs[6].exp);

    // all 256 operands, random exponents, random out_ready
    st_a.delete(); st_e.delete();
    for (int i = 0; i < 256; i++) begin
      st_a.push_back(8'(i));
      st_e.push_back(8'($urandom_range(0, 255)));
    end
    run_stream(1);

`ifdef DW_LOD_NORM_STATS_EN
    @(posedge clk); #1;
    check_val("stat_uflow_cnt", int'(bus.stat_uflow_cnt), tally_uflow);
    check_val("stat_zero_cnt",  int'(bus.stat_zero_cnt),  tally_zero);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h01;
    bus.in_exp    = 8'd0;
    repeat (65540) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("stat_uflow_sat", int'(bus.stat_uflow_cnt), 32'hFFFF);
    check_val("stat_zero_hold", int'(bus.stat_zero_cnt),  tally_zero);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dw_lod_norm_pipe.md
Name: dw_lod_norm_pipe

Overview:
Pipelined normalizer that sits directly downstream of the leading-one detector stage. Each accepted operand is left-shifted so its leading one lands in the MSB, and its exponent is reduced by the shift amount. The leading-one position, encoded as a leading-zero count, is computed internally.
Two-stage registered pipeline with valid/ready handshake on both sides; feeds the rounding/packing stage of the datapath.

Parameters:
a_width, 8, operand/mantissa width in bits (>=2)
addr_width, 4, shift-count width = ceil(log2(a_width))+1; must hold the value a_width
exp_width, 8, unsigned exponent width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept operand this cycle
in_a  input  a_width  operand to normalize
in_exp  input  exp_width  operand exponent (unsigned)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_norm  output  a_width  normalized operand
out_shift  output  addr_width  leading-zero count applied
out_exp  output  exp_width  adjusted exponent
out_zero  output  1  operand was all zeros
out_uflow  output  1  exponent underflow, clamped to 0

Behaviour:
- Reset (async assert, sync deassert by upstream): both stage valids = 0. out_valid = 0. All data outputs = 0. in_ready = 1 after the first clock with rst_n high.
- Reset mid-operation: in-flight items are discarded, with no partial output.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_valid and in_a/in_exp must be held stable until accepted.
  - Outputs hold stable while out_valid & !out_ready.
- Stage 1 (S1): registers in_a, in_exp and lzc. lzc = count of zeros above the highest set bit; lzc = a_width when in_a == 0.
- Stage 2 (S2): registers the following.
  - out_norm = s1_a << lzc (zero-filled).
  - out_shift = lzc.
  - out_zero = (s1_a == 0).
  - Exponent:
    - If zero: out_exp = 0, out_uflow = 0.
    - Else if s1_exp < lzc: out_exp = 0, out_uflow = 1.
    - Else: out_exp = s1_exp - lzc, out_uflow = 0.
- Advance rules:
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_adv, which is combinational from out_ready, with no comb path from in_valid.
- Latency: 2 cycles from acceptance to out_valid, with no backpressure.
- Throughput: 1 item/cycle sustained.
- Capacity: 2 items in flight.
- Full: both stages valid and out_ready = 0 -> in_ready = 0.
- Simultaneous in and out on a full pipe: accepted, no bubble.
- Ordering: strictly FIFO; no item dropped or duplicated.

Optional Feature:
Macro DW_LOD_NORM_STATS_EN.
- Defined:
  - Adds output stat_uflow_cnt (16 bits) and stat_zero_cnt (16 bits).
  - Each increments on an output transfer with out_uflow = 1 or out_zero = 1 respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent. Datapath behaviour is identical in both cases.

Decomposition:
- Shared package dw_lod_pkg holds:
  - the lzc width function (ceil(log2(a_width))+1);
  - constant STAT_CNT_W = 16;
  - a struct typedef for the stage payload {a, exp}.
- One sub-module, dw_lod_lzc: purely combinational leading-zero counter (a_width -> addr_width), instantiated in S1. It gives the same result as the encoder of the upstream leading-one detector, expressed as a leading-zero count.
- Pipeline registers and handshake live in the top.

Test Plan:
1. Basic normalize:
   - Stimulus: in_a = 8'b0001_0110, in_exp = 10, out_ready = 1.
   - Response, exactly 2 cycles later: out_norm = 8'b1011_0000, out_shift = 3, out_exp = 7, out_zero = 0, out_uflow = 0.
2. Zero operand:
   - Stimulus: in_a = 8'h00, in_exp = 20.
   - Response: out_norm = 0, out_shift = 8, out_exp = 0, out_zero = 1, out_uflow = 0.
3. Underflow and boundary:
   - in_a = 8'h01, in_exp = 2 -> out_shift = 7, out_exp = 0, out_uflow = 1.
   - in_a = 8'h01, in_exp = 7 -> out_exp = 0, out_uflow = 0.
   - in_a = 8'h80, in_exp = 0 -> out_shift = 0, out_exp = 0, out_uflow = 0.
4. Backpressure:
   - Stimulus: 4 back-to-back operands, out_ready = 0 for cycles 0-5, then 1.
   - Response:
     - in_ready falls after 2 accepts, and outputs hold stable while stalled.
     - Items 3 and 4 are accepted after release, and all 4 emerge in order.
     - 1/cycle throughput resumes with no bubble.
5. Reset mid-stream:
   - Stimulus: rst_n pulsed low while 2 items are in flight.
   - Response: out_valid drops asynchronously, all outputs 0, no stale item after release; the next operand gets normal 2-cycle latency.
6. Exhaustive random, with scoreboard:
   - Stimulus: all 256 in_a values × random in_exp, random out_ready.
   - Response: matches the reference model. With DW_LOD_NORM_STATS_EN defined, stat counters equal the scoreboard tallies, and saturation is checked by forcing more than 65535 underflows.
